// File: rtl/program_counter_pkg.sv
// Shared constants for the program counter: default geometry, reset value and
// the next-value mux select encoding used by every bit cell.
package program_counter_pkg;

  localparam int          PC_WIDTH       = 16;
  localparam int unsigned PC_RESET_VALUE = 0;

  localparam logic [1:0] SEL_RESET = 2'd0;
  localparam logic [1:0] SEL_LOAD  = 2'd1;
  localparam logic [1:0] SEL_INC   = 2'd2;
  localparam logic [1:0] SEL_HOLD  = 2'd3;

  // Reset is tested first so unknown load/inc values cannot leak into the select.
  function automatic logic [1:0] pc_select(input logic reset, input logic load,
                                           input logic inc);
    if (reset)     return SEL_RESET;
    else if (load) return SEL_LOAD;
    else if (inc)  return SEL_INC;
    else           return SEL_HOLD;
  endfunction

endpackage

// File: rtl/pc_bit_cell.sv
// One bit of program-counter storage: a D flip-flop fronted by the 4-way
// next-value mux (reset bit, load bit, incremented bit, current bit).
module pc_bit_cell
  import program_counter_pkg::*;
(
  input  logic       clk,
  input  logic [1:0] sel,
  input  logic       reset_bit,
  input  logic       in_bit,
  input  logic       inc_bit,
  output logic       q
);

  logic d;

  always_comb begin
    d = q;
    case (sel)
      SEL_RESET: d = reset_bit;
      SEL_LOAD:  d = in_bit;
      SEL_INC:   d = inc_bit;
      default:   d = q;
    endcase
  end

  always_ff @(posedge clk) begin
    q <= d;
  end

endmodule

// File: rtl/program_counter.sv
// WIDTH-bit program counter: per-bit storage cells sharing one ripple
// incrementer, plus a registered wrap flag for the all-ones to zero step.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int          WIDTH       = PC_WIDTH,
  parameter int unsigned RESET_VALUE = PC_RESET_VALUE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  output logic [WIDTH-1:0] out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RESET_BITS = WIDTH'(RESET_VALUE);

  logic [1:0]       sel;
  logic [WIDTH-1:0] inc_value;
  logic             carry;

  assign sel = pc_select(reset, load, inc);

  // Ripple incrementer; the final carry is set only when out is all-ones.
  always_comb begin
    carry     = 1'b1;
    inc_value = '0;
    for (int k = 0; k < WIDTH; k++) begin
      inc_value[k] = out[k] ^ carry;
      carry        = out[k] & carry;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pc_bit_cell u_cell (
      .clk       (clk),
      .sel       (sel),
      .reset_bit (RESET_BITS[i]),
      .in_bit    (in[i]),
      .inc_bit   (inc_value[i]),
      .q         (out[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) wrap <= 1'b0;
    else       wrap <= (sel == SEL_INC) && carry;
  end

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: directed test-plan sequences plus
// randomised control traffic checked against an arithmetic reference model.
module tb_program_counter;

  localparam int WIDTH = 16;
  localparam int unsigned RV = 0;
  localparam int unsigned MODULUS = 1 << WIDTH;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             wrap;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in;
  logic             load;
  logic             inc;
  logic [WIDTH-1:0] out;
  logic             wrap;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  exp_t mon_item;
  int unsigned model_pc;

  program_counter #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .load  (load),
    .inc   (inc),
    .out   (out),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  // Drive on the falling edge and queue what the next rising edge must produce.
  task automatic apply_stimulus(input logic r, input logic l, input logic i,
                                input logic [WIDTH-1:0] d);
    exp_t e;
    @(negedge clk);
    reset = r;
    load  = l;
    inc   = i;
    in    = d;
    if (r === 1'b1) begin
      model_pc = RV % MODULUS;
      e.wrap   = 1'b0;
    end else if (l === 1'b1) begin
      model_pc = int'(d);
      e.wrap   = 1'b0;
    end else if (i === 1'b1) begin
      e.wrap   = (model_pc == MODULUS - 1);
      model_pc = (model_pc + 1) % MODULUS;
    end else begin
      e.wrap   = 1'b0;
    end
    e.out = model_pc[WIDTH-1:0];
    exp_q.push_back(e);
  endtask

  task automatic check_output(input string name, input logic [WIDTH-1:0] eo,
                              input logic ew);
    @(posedge clk);
    #1;
    checks++;
    if (out !== eo || wrap !== ew) begin
      failures++;
      $display("[TB] FAIL %s: out=%h wrap=%b expected out=%h wrap=%b",
               name, out, wrap, eo, ew);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_item = exp_q.pop_front();
      checks++;
      if (out !== mon_item.out || wrap !== mon_item.wrap) begin
        failures++;
        $display("[TB] FAIL scoreboard @%0t: out=%h wrap=%b expected out=%h wrap=%b",
                 $time, out, wrap, mon_item.out, mon_item.wrap);
      end
    end
  end

  initial begin
    logic r, l, i;
    logic [WIDTH-1:0] d;
    model_pc = 0;

    apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    check_output("reset", 16'h0000, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1, 16'h0000);
      check_output("count", WIDTH'(k), 1'b0);
    end

    apply_stimulus(1'b0, 1'b1, 1'b1, 16'h1234);
    check_output("load_over_inc", 16'h1234, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    check_output("inc_after_load", 16'h1235, 1'b0);

    apply_stimulus(1'b0, 1'b1, 1'b0, 16'hFFFE);
    check_output("load_fffe", 16'hFFFE, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    check_output("inc_ffff", 16'hFFFF, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    check_output("wrap_zero", 16'h0000, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    check_output("after_wrap", 16'h0001, 1'b0);

    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0042);
    check_output("load_42", 16'h0042, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 16'hBEEF);
    check_output("reset_priority", 16'h0000, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    check_output("resume_after_reset", 16'h0001, 1'b0);

    apply_stimulus(1'b1, 1'bx, 1'bx, 16'hxxxx);
    check_output("reset_x_controls", 16'h0000, 1'b0);

    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h00A5);
    check_output("load_a5", 16'h00A5, 1'b0);
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, WIDTH'($urandom));
      check_output("hold", 16'h00A5, 1'b0);
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h00A5);
    check_output("load_same", 16'h00A5, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      r = ($urandom_range(0, 19) == 0);
      l = ($urandom_range(0, 3) == 0);
      i = ($urandom_range(0, 1) == 1);
      d = ($urandom_range(0, 3) == 0) ? 16'hFFFF : WIDTH'($urandom);
      apply_stimulus(r, l, i, d);
    end

    // Let the monitor drain, bounded so a stuck queue still reaches the summary.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: pending=%0d expected pending=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- 16-bit program counter for the CPU datapath, built on the team's gate-level D flip-flop storage.
- Sits downstream of the flip-flop cell: one flip-flop per bit holds state, and the counter adds next-value selection logic in front of it.
- Supplies the instruction-memory address each cycle.
- Accepts jump targets from the ALU/jump unit, and increments otherwise when enabled.

Parameters:
- WIDTH, 16, counter/address width in bits.
- RESET_VALUE, 0, value loaded on reset (truncated to WIDTH).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  jump target, sampled when load=1.
- load  input  1  load in into counter at next edge.
- inc  input  1  increment counter at next edge.
- out  output  WIDTH  current counter value (registered).
- wrap  output  1  registered flag: 1 for exactly the cycle after an increment from all-ones to zero.

Behaviour:
- Reset is synchronous, active-high.
  - When reset=1 at a rising edge: out <= RESET_VALUE and wrap <= 0, regardless of load/inc/in.
  - No asynchronous effect; outputs hold until the edge.
- Priority at each rising edge: reset > load > inc > hold.
  - load=1 (reset=0): out <= in; wrap <= 0. inc is ignored in this cycle.
  - inc=1, load=0, reset=0: out <= out + 1 modulo 2^WIDTH; wrap <= 1 iff old out == all-ones, else 0.
  - All controls 0: out holds; wrap <= 0.
- Latency: every change is visible on out one cycle after the edge that samples the controls. No combinational path from inputs to out or wrap.
- Wrap-around: increment from 2^WIDTH-1 gives 0 and pulses wrap for one cycle. No saturation, no sticky flag.
- Load of the current value (in == out) is a legal no-op; wrap=0.
- Reset mid-sequence (e.g. during back-to-back increments or a load) aborts the pending update; the following cycle resumes from RESET_VALUE.
- X/undefined on load/inc while reset=1 must not propagate: reset output is fully defined.
- Before the first reset, out is undefined. The bench must not check before reset.
- State machine: implicit. State = out. Transitions are selected by the priority encoder above.
- Arithmetic: ripple incrementer, WIDTH bits, carry-out of MSB used only to form wrap. No signed interpretation.

Decomposition:
- Shared package/header:
  - PC_WIDTH (16).
  - PC_RESET_VALUE (0).
  - Control-priority encoding constants (SEL_RESET, SEL_LOAD, SEL_INC, SEL_HOLD) for the 4-way next-value mux select.
- One sub-module is natural: pc_bit_cell.
  - One bit of storage wrapping the existing flip-flop.
  - Fronted by the 4-way next-value mux (reset value bit, in bit, incremented bit, current bit).
  - program_counter instantiates WIDTH of them plus the shared incrementer and wrap flip-flop.

Test Plan:
1. Reset then inc=1 for 5 cycles -> out = 0,1,2,3,4,5 on successive cycles; wrap=0 throughout.
2. From out=3, load=1, in=0x1234 (inc=1 also) -> next cycle out=0x1234; following cycle with inc=1 only -> 0x1235.
3. load=1, in=0xFFFE, then inc=1 for 3 cycles -> out = 0xFFFE, 0xFFFF, 0x0000, 0x0001; wrap=1 only in the cycle out=0x0000.
4. Counting at out=0x0042, reset=1 with load=1, in=0xBEEF, inc=1 for one cycle -> out=0x0000, wrap=0; next cycle inc=1 -> 0x0001.
5. All controls 0 for 10 cycles after load of 0x00A5 -> out stays 0x00A5, wrap=0.
6. Randomised 1000 cycles of {reset, load, inc, in} against a reference model applying reset>load>inc>hold -> out and wrap match every cycle.
